// File: rtl/bdt_tree_scheduler.sv
// Time-multiplexes one shared decision_function evaluator across NUM_TREES trees and
// accumulates the per-tree scores with saturation into a valid/ready ensemble output.
//
// state | meaning
// IDLE  | waiting for a sample, in_ready high
// ISSUE | tree_start held for tree idx until tree_ready
// WAIT  | start accepted, waiting for tree_done or the wait timeout
// DONE  | out_valid held with the ensemble sum until out_ready
module bdt_tree_scheduler #(
    parameter int NUM_TREES = 8,
    parameter int SCORE_W   = 18,
    parameter int ACC_W     = 24,
    parameter int TIMEOUT   = 1023,
    parameter int ID_W      = (NUM_TREES > 1) ? $clog2(NUM_TREES) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      tree_start,
    output logic [ID_W-1:0]           tree_id,
    input  logic                      tree_ready,
    input  logic                      tree_done,
    input  logic signed [SCORE_W-1:0] tree_score,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [ACC_W-1:0]   out_score,
    output logic                      busy,
    output logic                      err_timeout
);
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_TREES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                  state;
    logic [ID_W-1:0]         idx;
    logic signed [ACC_W-1:0] acc;
    logic [TMO_W-1:0]        wait_cnt;
    logic                    tmo_hit;
    logic                    step;

    // One extra bit of headroom makes overflow visible as a sign disagreement.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0]   a,
        input logic signed [SCORE_W-1:0] s
    );
        logic signed [ACC_W:0] sum;
        sum = {a[ACC_W-1], a} + {{(ACC_W + 1 - SCORE_W){s[SCORE_W-1]}}, s};
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            return sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        return sum[ACC_W-1:0];
    endfunction

    // wait_cnt counts down from TIMEOUT-1, so terminal count lands on the T-th WAIT cycle.
    assign tmo_hit   = (TIMEOUT != 0) && (wait_cnt == '0);
    assign step      = ((state == WAIT) && (tree_done || tmo_hit)) ||
                       ((state == ISSUE) && tree_ready && tree_done);
    assign tree_id   = idx;
    assign out_score = acc;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            acc         <= '0;
            wait_cnt    <= '0;
            in_ready    <= 1'b1;
            tree_start  <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc        <= '0;
                        idx        <= '0;
                        state      <= ISSUE;
                        in_ready   <= 1'b0;
                        tree_start <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ISSUE, WAIT: begin
                    if (step) begin
                        if (tree_done) begin
                            acc <= sat_add(acc, tree_score);
                        end else begin
                            err_timeout <= 1'b1;
                        end
                        if (idx == LAST_ID) begin
                            state      <= DONE;
                            tree_start <= 1'b0;
                            out_valid  <= 1'b1;
                        end else begin
                            idx        <= idx + 1'b1;
                            state      <= ISSUE;
                            tree_start <= 1'b1;
                        end
                    end else if ((state == ISSUE) && tree_ready) begin
                        state      <= WAIT;
                        tree_start <= 1'b0;
                        wait_cnt   <= TMO_LOAD;
                    end else if (state == WAIT) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bdt_tree_scheduler.sv
// Scoreboard bench for bdt_tree_scheduler: a behavioural evaluator model drives the tree
// side, expected ensemble sums are queued per sample and checked by an independent monitor.
module tb_bdt_tree_scheduler;
    localparam int NT   = 8;
    localparam int SW   = 18;
    localparam int AW   = 18;
    localparam int TMO  = 10;
    localparam int IW   = 3;
    localparam int SMAX = 131071;
    localparam int SMIN = -131072;

    logic clock = 1'b0;
    logic reset;
    logic in_valid, in_ready, tree_start, tree_ready, tree_done;
    logic out_valid, out_ready, busy, err_timeout;
    logic [IW-1:0] tree_id;
    logic signed [SW-1:0] tree_score;
    logic signed [AW-1:0] out_score;

    bdt_tree_scheduler #(
        .NUM_TREES(NT), .SCORE_W(SW), .ACC_W(AW), .TIMEOUT(TMO), .ID_W(IW)
    ) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .tree_start(tree_start), .tree_id(tree_id), .tree_ready(tree_ready),
        .tree_done(tree_done), .tree_score(tree_score), .out_valid(out_valid),
        .out_ready(out_ready), .out_score(out_score), .busy(busy),
        .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int sum;
        bit err;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];

    int cfg_score[NT];
    int cfg_lat[NT];
    bit cfg_dead[NT];
    bit cfg_late[NT];
    bit rand_ev     = 1'b0;
    bit rand_out    = 1'b0;
    bit err_model   = 1'b0;
    int hold_cycles = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: add tree scores in tree order, clamping after every addition.
    function automatic int ref_sum();
        int s = 0;
        for (int i = 0; i < NT; i++) begin
            if (!cfg_dead[i]) begin
                s = s + cfg_score[i];
                if (s > SMAX) s = SMAX;
                if (s < SMIN) s = SMIN;
            end
        end
        return s;
    endfunction

    // Accept-to-first-sampled-out_valid: one issue cycle per tree plus its wait, plus one.
    function automatic int ref_lat();
        int l = 1;
        for (int i = 0; i < NT; i++) l = l + 1 + (cfg_dead[i] ? TMO : cfg_lat[i]);
        return l;
    endfunction

    // Evaluator model
    bit ev_busy = 1'b0;
    int ev_rem = 0;
    int ev_score = 0;
    int ev_exp_id = 0;
    initial begin
        bit was_busy;
        int id;
        tree_ready = 1'b0;
        tree_done  = 1'b0;
        tree_score = '0;
        forever begin
            @(negedge clock);
            #1;
            tree_ready = 1'b0;
            tree_done  = 1'b0;
            if (reset) begin
                ev_busy   = 1'b0;
                ev_exp_id = 0;
                continue;
            end
            was_busy = ev_busy;
            if (ev_busy) begin
                ev_rem--;
                if (ev_rem == 0) begin
                    tree_done  = 1'b1;
                    tree_score = ev_score[SW-1:0];
                    ev_busy    = 1'b0;
                end
            end
            if (tree_start && !was_busy && (!rand_ev || $urandom_range(0, 2) != 0)) begin
                id = int'(tree_id);
                tree_ready = 1'b1;
                check("tree_id", id, ev_exp_id);
                ev_exp_id = (ev_exp_id + 1) % NT;
                if (cfg_late[id]) begin
                    ev_busy  = 1'b1;
                    ev_rem   = TMO + 2;
                    ev_score = SMAX;
                end else if (!cfg_dead[id]) begin
                    if (cfg_lat[id] == 0) begin
                        tree_done  = 1'b1;
                        tree_score = cfg_score[id][SW-1:0];
                    end else begin
                        ev_busy  = 1'b1;
                        ev_rem   = cfg_lat[id];
                        ev_score = cfg_score[id];
                    end
                end
            end else if (rand_ev && !tree_done && (tree_start || !busy || out_valid) &&
                         $urandom_range(0, 3) == 0) begin
                // stray done pulses where the scheduler must ignore them
                tree_done  = 1'b1;
                tree_score = SW'($urandom);
            end
        end
    end

    // Consumer side
    initial begin
        int held = 0;
        out_ready = 1'b0;
        forever begin
            @(negedge clock);
            if (!out_valid) held = 0;
            if (rand_out) out_ready = ($urandom_range(0, 2) != 0);
            else if (out_valid && held < hold_cycles) begin
                out_ready = 1'b0;
                held++;
            end else out_ready = 1'b1;
        end
    end

    // Monitor
    initial begin
        bit   prev_valid = 1'b0;
        bit   prev_hs = 1'b0;
        bit   have = 1'b0;
        exp_t e;
        int   k;
        forever begin
            @(negedge clock);
            #2;
            if (reset) begin
                prev_valid = 1'b0;
                prev_hs    = 1'b0;
                have       = 1'b0;
                continue;
            end
            if (prev_hs) check("idle_after_handshake", {in_ready, busy, out_valid}, 3'b100);
            prev_hs = 1'b0;
            if (have && !out_valid) begin
                total++;
                bad++;
                $display("FAIL out_valid_dropped: out_valid=0 before handshake, required 1");
                have = 1'b0;
            end
            if (in_valid && in_ready) acc_q.push_back(cyc + 1);
            if (out_valid) begin
                if (!prev_valid) begin
                    if (exp_q.size() == 0 || acc_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out_valid: out_valid=1 score=%0d with no sample pending",
                                 int'(out_score));
                    end else begin
                        e = exp_q.pop_front();
                        k = acc_q.pop_front();
                        have = 1'b1;
                        if (e.lat >= 0) check("latency", cyc + 1 - k, e.lat);
                        check("err_timeout", int'(err_timeout), int'(e.err));
                    end
                end
                if (have) check("out_score", int'(out_score), e.sum);
                check("in_ready_in_done", int'(in_ready), 0);
                if (out_ready) begin
                    prev_hs = 1'b1;
                    have    = 1'b0;
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (!in_ready && t < 3000) begin
            @(negedge clock);
            t++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL wait_idle: in_ready=0 after %0d cycles, required 1", t);
        end
    endtask

    task automatic send_sample();
        exp_t e;
        bit any_late = 1'b0;
        wait_idle();
        for (int i = 0; i < NT; i++) begin
            if (cfg_late[i]) any_late = 1'b1;
            if (cfg_dead[i]) err_model = 1'b1;
        end
        e.sum = ref_sum();
        e.err = err_model;
        e.lat = (rand_ev || any_late) ? -1 : ref_lat();
        exp_q.push_back(e);
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic set_cfg(input int score, input int lat);
        for (int i = 0; i < NT; i++) begin
            cfg_score[i] = score;
            cfg_lat[i]   = lat;
            cfg_dead[i]  = 1'b0;
            cfg_late[i]  = 1'b0;
        end
    endtask

    task automatic apply_reset(input int n);
        reset    = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        acc_q.delete();
        repeat (n) @(negedge clock);
        reset     = 1'b0;
        err_model = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_tree_start", int'(tree_start), 0);
        check("rst_tree_id", int'(tree_id), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_score", int'(out_score), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err_timeout", int'(err_timeout), 0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        set_cfg(0, 0);
        @(negedge clock);
        apply_reset(2);

        // basic sum: combinational evaluator, score = tree_id + 1
        for (int i = 0; i < NT; i++) cfg_score[i] = i + 1;
        send_sample();

        // evaluator latency 3, alternating +100/-40, consumer stalls 5 cycles
        wait_idle();
        hold_cycles = 5;
        set_cfg(0, 3);
        for (int i = 0; i < NT; i++) cfg_score[i] = (i % 2 == 0) ? 100 : -40;
        send_sample();
        wait_idle();
        hold_cycles = 0;

        // saturation at both rails, and clamping applied per addition
        set_cfg(SMAX, 0);
        send_sample();
        wait_idle();
        set_cfg(SMIN, 1);
        send_sample();
        wait_idle();
        set_cfg(0, 0);
        cfg_score[0] = SMAX;
        cfg_score[1] = SMAX;
        cfg_score[2] = -100000;
        send_sample();

        // randomized traffic with ready stalls, stray dones and consumer backpressure
        wait_idle();
        rand_ev  = 1'b1;
        rand_out = 1'b1;
        for (int n = 0; n < 30; n++) begin
            wait_idle();
            for (int i = 0; i < NT; i++) begin
                cfg_lat[i]  = $urandom_range(0, 4);
                cfg_dead[i] = 1'b0;
                cfg_late[i] = 1'b0;
                if ($urandom_range(0, 1) == 1) cfg_score[i] = int'($urandom_range(0, 2000)) - 1000;
                else cfg_score[i] = int'($urandom_range(0, 262143)) - 131072;
            end
            send_sample();
        end
        wait_idle();
        rand_ev  = 1'b0;
        rand_out = 1'b0;

        // tree 3 never finishes; then a late done for tree 3; then a clean sample
        wait_idle();
        set_cfg(5, 0);
        cfg_dead[3] = 1'b1;
        send_sample();
        wait_idle();
        cfg_late[3] = 1'b1;
        send_sample();
        wait_idle();
        set_cfg(5, 0);
        send_sample();

        // reset while waiting on tree 4
        wait_idle();
        set_cfg(7, 5);
        send_sample();
        begin
            int t = 0;
            while (!(busy && !tree_start && int'(tree_id) == 4) && t < 300) begin
                @(negedge clock);
                t++;
            end
            check("reached_wait_tree4", int'(busy && !tree_start && int'(tree_id) == 4), 1);
        end
        reset = 1'b1;
        exp_q.delete();
        acc_q.delete();
        @(negedge clock);
        reset     = 1'b0;
        err_model = 1'b0;
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_err_timeout", int'(err_timeout), 0);
        repeat (20) @(negedge clock);
        set_cfg(0, 0);
        for (int i = 0; i < NT; i++) cfg_score[i] = i + 1;
        send_sample();

        begin
            int t = 0;
            while ((exp_q.size() != 0 || out_valid) && t < 3000) begin
                @(negedge clock);
                t++;
            end
            if (exp_q.size() != 0 || out_valid) begin
                total++;
                bad++;
                $display("FAIL drain: %0d samples still pending, required 0", exp_q.size());
            end
        end
        repeat (5) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
